spi_slave_regfile: RTL and testbench
====================================

# spi_slave_regfile

Parametrised configuration/status register file for the SPI slave, clocked directly by the SPI clock. It supersedes the fixed four-register file with NUM_REGS registers, an auto-incrementing burst address pointer, sticky write-1-to-clear status bits and a key-protected write lock on the configuration registers. It sits between the SPI command decoder and the QPI/dummy-cycle/wrap logic of the slave datapath.

## Interface

- REG_SIZE, 8: register width in bits; must be at least 8.
- ADDR_W, 3: address width; NUM_REGS = 2**ADDR_W; must be at least 3.
- DUMMY_RST, 32: reset value of reg1 (dummy cycles).
- UNLOCK_KEY, 'h5A: key value that arms unlocking.
- LOCK_RST, 0: reset value of the lock bit.

- sclk  in  1  SPI clock; all state updates on its rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- acc_start  in  1  one-cycle pulse; loads the burst pointer from acc_addr.
- acc_addr  in  ADDR_W  burst start address.
- wr_data  in  REG_SIZE  write data.
- wr_data_valid  in  1  write wr_data at the current address, then increment the pointer.
- rd_next  in  1  increment the pointer after a read beat.
- rd_data  out  REG_SIZE  combinational contents of the register at the current pointer.
- status_set  in  REG_SIZE  per-bit set pulses into the status register (reg4).
- en_qpi  out  1  reg0[0].
- dummy_cycles  out  8  reg1[7:0].
- wrap_length  out  2*REG_SIZE  {reg3, reg2}.
- locked  out  1  reg5[0]; while high, reg0–reg3 are write-protected.
- wr_err  out  1  registered one-cycle pulse for a write rejected by the lock.

## Operation

Register map:
- reg0–reg3: configuration registers, with the same meaning as the legacy map.
- reg4: sticky status register.
- reg5: lock register. Bit 0 is the lock; the other bits read as 0.
- reg6..NUM_REGS-1: scratch registers. Read/write, reset to 0.

Pointer (ptr, ADDR_W bits):
- Effective address ea = acc_start ? acc_addr : ptr.
- On a cycle with acc_start, wr_data_valid or rd_next, ptr <= ea + 1 if wr_data_valid or rd_next is high; otherwise ptr <= acc_addr.
- wr_data_valid and rd_next in the same cycle cause a single increment.
- The pointer wraps from NUM_REGS-1 to 0 by modular arithmetic.
- rd_data = reg[ptr]. A read in the same cycle as acc_start is not supported; rd_data reflects the new address one cycle later.

Writes at ea:
- reg0–reg3: written only if locked == 0. Otherwise the write is dropped and wr_err pulses on the next cycle.
- reg4 (write-1-to-clear): next = (reg4 & ~wr_data) | status_set. A set and a clear of the same bit in the same cycle leave the bit set. status_set is ORed in every cycle, whether or not a write occurs.
- reg5: governed by the lock FSM below.
- Scratch registers: plain write.

Lock FSM, states LOCKED, ARMED, OPEN:
- Reset state: LOCKED if LOCK_RST = 1, otherwise OPEN. locked = (state != OPEN).
- OPEN: a reg5 write with wr_data[0] = 1 moves to LOCKED.
- LOCKED: a reg5 write of exactly UNLOCK_KEY moves to ARMED.
- ARMED:
  - The next write to any address decides the outcome: a reg5 write with wr_data[0] = 0 moves to OPEN.
  - Any other write moves to LOCKED; if that write targeted reg0–reg3, it is rejected and wr_err pulses.
  - Cycles without a write keep the FSM in ARMED.
- A reg5 write in LOCKED that is not the key leaves the FSM in LOCKED and does not assert wr_err.
- reg5 reads back {0…, locked}.

## Timing

- Reset values: reg0 = 0, reg1 = DUMMY_RST, reg2 = reg3 = reg4 = 0, scratch = 0, ptr = 0, wr_err = 0, locked = LOCK_RST.
- At reset release the outputs read: en_qpi = 0, dummy_cycles = DUMMY_RST[7:0], wrap_length = 0, and rd_data = reg0.
- Write latency is one edge: the written value is visible on rd_data and the derived outputs after the rising edge on which wr_data_valid was sampled.
- wr_err is high for exactly one cycle, starting the cycle after the rejected write.
- Asserting rstn mid-burst returns every register, the pointer and the FSM to their reset values immediately (asynchronous reset).

## Test plan

- Reset check: release rstn with no accesses -> dummy_cycles = 32, en_qpi = 0, wrap_length = 0, locked = 0, rd_data = reg0 = 0.
- Burst write with wrap: acc_start with acc_addr = 6, then write 'h11, 'h22, 'h33 on consecutive cycles -> reg6 = 'h11, reg7 = 'h22, reg0 = 'h33; en_qpi = 1; ptr = 1.
- Lock rejection: write reg5 = 1, then write reg1 = 'h08 -> reg1 stays at 32, wr_err pulses for 1 cycle, and locked = 1.
- Unlock sequence:
  - reg5 = 'h5A followed by reg5 = 0 -> locked = 0, and a subsequent write of reg1 = 'h08 takes effect.
  - reg5 = 'h5A followed by a write to reg2 -> the reg2 write is rejected, wr_err pulses, and the FSM returns to LOCKED.
- Sticky status: set status_set = 'h05 for one cycle -> reg4 = 'h05. Then write reg4 = 'h01 while status_set = 'h01 -> reg4 = 'h05. Then write reg4 = 'h04 -> reg4 = 'h01.
- Reset mid-burst: start a burst at address 2, pulse rstn low after one write -> ptr = 0 and all registers return to their reset values.

Source files
------------

// File: rtl/spi_slave_regfile_if.sv
// Register-file access bus between the SPI command decoder and the regfile.
// master: decoder side (drives accesses); slave: regfile side (drives outputs).
interface spi_slave_regfile_if #(
  parameter int REG_SIZE = 8,
  parameter int ADDR_W   = 3
);
  logic                  acc_start;
  logic [ADDR_W-1:0]     acc_addr;
  logic [REG_SIZE-1:0]   wr_data;
  logic                  wr_data_valid;
  logic                  rd_next;
  logic [REG_SIZE-1:0]   rd_data;
  logic [REG_SIZE-1:0]   status_set;
  logic                  en_qpi;
  logic [7:0]            dummy_cycles;
  logic [2*REG_SIZE-1:0] wrap_length;
  logic                  locked;
  logic                  wr_err;

  modport master (
    output acc_start, acc_addr, wr_data,
    output wr_data_valid, rd_next, status_set,
    input  rd_data, en_qpi, dummy_cycles,
    input  wrap_length, locked, wr_err
  );

  modport slave (
    input  acc_start, acc_addr, wr_data,
    input  wr_data_valid, rd_next, status_set,
    output rd_data, en_qpi, dummy_cycles,
    output wrap_length, locked, wr_err
  );
endinterface

// File: rtl/spi_slave_regfile.sv
// SPI slave config/status regfile: burst pointer, W1C status, keyed lock.
// Ports: sclk, rstn (async active-low), bus (slave modport, access + outputs).
module spi_slave_regfile #(
  parameter int REG_SIZE   = 8,
  parameter int ADDR_W     = 3,
  parameter int DUMMY_RST  = 32,
  parameter int UNLOCK_KEY = 'h5A,
  parameter int LOCK_RST   = 0
) (
  input logic                sclk,
  input logic                rstn,
  spi_slave_regfile_if.slave bus
);

  localparam int NUM_REGS = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] STAT_A = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] LOCK_A = ADDR_W'(5);

  typedef enum logic [1:0] {
    S_OPEN   = 2'd0,
    S_LOCKED = 2'd1,
    S_ARMED  = 2'd2
  } lock_st_e;

  logic [REG_SIZE-1:0] regs_q [NUM_REGS];
  logic [REG_SIZE-1:0] regs_d [NUM_REGS];
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                wr_err_q, wr_err_d;
  lock_st_e            state_q, state_d;

  logic [ADDR_W-1:0]   ea;
  logic                locked_w;
  logic                is_cfg, is_stat, is_lock;
  logic [REG_SIZE-1:0] clr_mask;

  assign locked_w = (state_q != S_OPEN);

  always_comb begin
    ea       = bus.acc_start ? bus.acc_addr : ptr_q;
    is_cfg   = (ea < ADDR_W'(4));
    is_stat  = (ea == STAT_A);
    is_lock  = (ea == LOCK_A);
    ptr_d    = ptr_q;
    regs_d   = regs_q;
    state_d  = state_q;
    wr_err_d = 1'b0;
    clr_mask = '0;

    // One increment even when a write and a read beat coincide.
    if (bus.wr_data_valid || bus.rd_next)
      ptr_d = ea + ADDR_W'(1);
    else if (bus.acc_start)
      ptr_d = bus.acc_addr;

    if (bus.wr_data_valid) begin
      unique case (1'b1)
        is_cfg: begin
          if (locked_w) wr_err_d = 1'b1;
          else          regs_d[ea] = bus.wr_data;
        end
        is_stat: clr_mask = bus.wr_data;
        is_lock: ;
        default: regs_d[ea] = bus.wr_data;
      endcase

      // ARMED resolves on the very next write, whatever its target.
      unique case (state_q)
        S_OPEN: begin
          if (is_lock && bus.wr_data[0])
            state_d = S_LOCKED;
        end
        S_LOCKED: begin
          if (is_lock &&
              bus.wr_data == REG_SIZE'(UNLOCK_KEY))
            state_d = S_ARMED;
        end
        S_ARMED: begin
          if (is_lock && !bus.wr_data[0])
            state_d = S_OPEN;
          else
            state_d = S_LOCKED;
        end
        default: state_d = S_LOCKED;
      endcase
    end

    // Set wins over a same-cycle clear.
    regs_d[STAT_A] = (regs_q[STAT_A] & ~clr_mask)
                   | bus.status_set;
    // reg5 has no storage; it reads back from the FSM.
    regs_d[LOCK_A] = '0;
  end

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs_q[i] <= (i == 1) ? REG_SIZE'(DUMMY_RST)
                              : '0;
      ptr_q    <= '0;
      wr_err_q <= 1'b0;
      state_q  <= (LOCK_RST != 0) ? S_LOCKED : S_OPEN;
    end else begin
      regs_q   <= regs_d;
      ptr_q    <= ptr_d;
      wr_err_q <= wr_err_d;
      state_q  <= state_d;
    end
  end

  assign bus.rd_data = (ptr_q == LOCK_A)
    ? {{(REG_SIZE-1){1'b0}}, locked_w}
    : regs_q[ptr_q];
  assign bus.en_qpi       = regs_q[0][0];
  assign bus.dummy_cycles = regs_q[1][7:0];
  assign bus.wrap_length  = {regs_q[3], regs_q[2]};
  assign bus.locked       = locked_w;
  assign bus.wr_err       = wr_err_q;

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Directed self-checking bench for spi_slave_regfile.
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_spi_slave_regfile;

  logic sclk;
  logic rstn;
  int   tests;
  int   fails;

  spi_slave_regfile_if #(.REG_SIZE(8), .ADDR_W(3)) bus ();

  spi_slave_regfile #(
    .REG_SIZE(8), .ADDR_W(3), .DUMMY_RST(32),
    .UNLOCK_KEY('h5A), .LOCK_RST(0)
  ) dut (
    .sclk(sclk),
    .rstn(rstn),
    .bus (bus)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  task automatic idle();
    bus.acc_start     = 1'b0;
    bus.acc_addr      = '0;
    bus.wr_data       = '0;
    bus.wr_data_valid = 1'b0;
    bus.rd_next       = 1'b0;
    bus.status_set    = '0;
  endtask

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a,
                    input logic [7:0] d);
    bus.acc_start     = 1'b1;
    bus.acc_addr      = a;
    bus.wr_data       = d;
    bus.wr_data_valid = 1'b1;
    tick();
    idle();
  endtask

  task automatic seek(input logic [2:0] a);
    bus.acc_start = 1'b1;
    bus.acc_addr  = a;
    tick();
    idle();
  endtask

  task automatic chk(input string nm,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic test_reset();
    idle();
    rstn = 1'b0;
    #12;
    rstn = 1'b1;
    tick();
    if (bus.dummy_cycles !== 8'd32) begin
      fails++;
      $display("FAIL rst_dummy: got %0d expected 32",
               bus.dummy_cycles);
    end
    tests++;
    if (bus.en_qpi !== 1'b0) begin
      fails++;
      $display("FAIL rst_qpi: got %b expected 0", bus.en_qpi);
    end
    tests++;
    if (bus.wrap_length !== 16'h0) begin
      fails++;
      $display("FAIL rst_wrap: got %h expected 0000",
               bus.wrap_length);
    end
    tests++;
    if (bus.locked !== 1'b0) begin
      fails++;
      $display("FAIL rst_locked: got %b expected 0", bus.locked);
    end
    tests++;
    if (bus.rd_data !== 8'h00) begin
      fails++;
      $display("FAIL rst_rd: got %h expected 00", bus.rd_data);
    end
    tests++;
    if (bus.wr_err !== 1'b0) begin
      fails++;
      $display("FAIL rst_err: got %b expected 0", bus.wr_err);
    end
    tests++;
  endtask

  task automatic test_burst_wrap();
    logic [7:0] dat [3];
    dat[0] = 8'h11; dat[1] = 8'h22; dat[2] = 8'h33;
    seek(3'd6);
    for (int i = 0; i < 3; i++) begin
      bus.wr_data       = dat[i];
      bus.wr_data_valid = 1'b1;
      tick();
    end
    idle();
    if (bus.en_qpi !== 1'b1) begin
      fails++;
      $display("FAIL burst_qpi: got %b expected 1", bus.en_qpi);
    end
    tests++;
    // ptr now 1, so rd_data shows reg1 = 32
    if (bus.rd_data !== 8'd32) begin
      fails++;
      $display("FAIL burst_ptr: got %h expected 20", bus.rd_data);
    end
    tests++;
    seek(3'd6);
    for (int i = 0; i < 3; i++) begin
      if (bus.rd_data !== dat[i]) begin
        fails++;
        $display("FAIL burst_rd%0d: got %h expected %h",
                 i, bus.rd_data, dat[i]);
      end
      tests++;
      bus.rd_next = 1'b1;
      tick();
      idle();
    end
  endtask

  task automatic test_lock_reject();
    wr(3'd5, 8'h01);
    if (bus.locked !== 1'b1) begin
      fails++;
      $display("FAIL lock_set: got %b expected 1", bus.locked);
    end
    tests++;
    wr(3'd1, 8'h08);
    if (bus.wr_err !== 1'b1) begin
      fails++;
      $display("FAIL lock_err: got %b expected 1", bus.wr_err);
    end
    tests++;
    tick();
    if (bus.wr_err !== 1'b0) begin
      fails++;
      $display("FAIL lock_err_len: got %b expected 0",
               bus.wr_err);
    end
    tests++;
    if (bus.dummy_cycles !== 8'd32) begin
      fails++;
      $display("FAIL lock_keep: got %0d expected 32",
               bus.dummy_cycles);
    end
    tests++;
    seek(3'd5);
    if (bus.rd_data !== 8'h01) begin
      fails++;
      $display("FAIL lock_rd5: got %h expected 01", bus.rd_data);
    end
    tests++;
  endtask

  task automatic test_unlock();
    wr(3'd5, 8'h5A);
    chk("arm_locked", {15'd0, bus.locked}, 16'd1);
    wr(3'd5, 8'h00);
    chk("unlock", {15'd0, bus.locked}, 16'd0);
    wr(3'd1, 8'h08);
    chk("unlock_wr", {8'd0, bus.dummy_cycles}, 16'd8);
    wr(3'd5, 8'h01);
    wr(3'd5, 8'h5A);
    wr(3'd2, 8'hAB);
    chk("arm_rej_err", {15'd0, bus.wr_err}, 16'd1);
    chk("arm_rej_wrap", bus.wrap_length, 16'h0000);
    // back in LOCKED: a clear-lock write is not the key
    wr(3'd5, 8'h00);
    chk("relocked", {15'd0, bus.locked}, 16'd1);
    chk("nonkey_noerr", {15'd0, bus.wr_err}, 16'd0);
    wr(3'd5, 8'h5A);
    wr(3'd5, 8'h00);
    wr(3'd2, 8'h34);
    wr(3'd3, 8'h12);
    chk("wrap_len", bus.wrap_length, 16'h1234);
  endtask

  task automatic test_sticky();
    bus.status_set = 8'h05;
    tick();
    idle();
    seek(3'd4);
    chk("stat_set", {8'd0, bus.rd_data}, 16'h05);
    bus.status_set = 8'h01;
    wr(3'd4, 8'h01);
    seek(3'd4);
    chk("stat_setwins", {8'd0, bus.rd_data}, 16'h05);
    wr(3'd4, 8'h04);
    seek(3'd4);
    chk("stat_clr", {8'd0, bus.rd_data}, 16'h01);
  endtask

  task automatic test_back_to_back();
    seek(3'd6);
    bus.wr_data       = 8'h77;
    bus.wr_data_valid = 1'b1;
    bus.rd_next       = 1'b1;
    tick();
    idle();
    // single increment: ptr 7 shows reg7 = 22
    chk("b2b_ptr", {8'd0, bus.rd_data}, 16'h22);
    seek(3'd6);
    chk("b2b_wr", {8'd0, bus.rd_data}, 16'h77);
  endtask

  task automatic test_reset_mid();
    seek(3'd2);
    bus.wr_data       = 8'h55;
    bus.wr_data_valid = 1'b1;
    tick();
    chk("mid_wr", bus.wrap_length, 16'h1255);
    bus.wr_data = 8'h66;
    #2;
    rstn = 1'b0;
    #1;
    chk("mid_async", {8'd0, bus.dummy_cycles}, 16'd32);
    chk("mid_wrap", bus.wrap_length, 16'h0000);
    chk("mid_qpi", {15'd0, bus.en_qpi}, 16'd0);
    idle();
    #10;
    rstn = 1'b1;
    tick();
    chk("mid_ptr", {8'd0, bus.rd_data}, 16'h00);
    seek(3'd4);
    chk("mid_stat", {8'd0, bus.rd_data}, 16'h00);
    seek(3'd6);
    chk("mid_scr", {8'd0, bus.rd_data}, 16'h00);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rstn  = 1'b1;
    idle();
    test_reset();
    test_burst_wrap();
    test_lock_reject();
    test_unlock();
    test_sticky();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
